// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_ctrl_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] BUBBLE = 16'h0000;
    localparam logic [3:0]        HLT_OP = 4'b1111;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_t;

    function automatic logic is_hlt(input logic [WORD_W-1:0] instr, input logic [3:0] op);
        return instr[WORD_W-1:WORD_W-4] == op;
    endfunction

endpackage

// File: rtl/fetch_ctrl_dff.sv
// rtl/fetch_ctrl_dff.sv - enable-gated register with synchronous active-high reset
module fetch_ctrl_dff #(
    parameter int         WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing and IF/ID register with stall, branch and halt handling
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] BUBBLE   = fetch_ctrl_pkg::BUBBLE,
    parameter logic [3:0]  HLT_OP   = fetch_ctrl_pkg::HLT_OP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        hlt,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    import fetch_ctrl_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic              pc_wen;
    logic [WORD_W-1:0] pc_plus2;

    logic [WORD_W-1:0] instr_d;
    logic [WORD_W-1:0] pp2_d;
    logic              valid_d;
    logic              ifid_wen;
    logic              stall_inc;

    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // One priority chain: hlt beats branch beats stall beats a normal fetch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_wen    = 1'b0;
        instr_d   = if_id_instr;
        pp2_d     = if_id_pc_plus2;
        valid_d   = if_id_valid;
        ifid_wen  = 1'b0;
        stall_inc = 1'b0;

        if (state_q != HALTED) begin
            if (hlt) begin
                state_d = HALTED;
            end else if (branch_taken) begin
                state_d  = FETCH;
                pc_d     = branch_target;
                pc_wen   = 1'b1;
                instr_d  = BUBBLE;
                pp2_d    = branch_target;
                valid_d  = 1'b0;
                ifid_wen = 1'b1;
            end else if (stall) begin
                stall_inc = 1'b1;
            end else if (state_q == FETCH) begin
                instr_d  = imem_data;
                pp2_d    = pc_plus2;
                valid_d  = 1'b1;
                ifid_wen = 1'b1;
                // The HLT word itself still enters IF/ID; only the PC stops advancing.
                if (is_hlt(imem_data, HLT_OP)) begin
                    state_d = HALT_PEND;
                end else begin
                    pc_d   = pc_plus2;
                    pc_wen = 1'b1;
                end
            end else begin
                instr_d  = BUBBLE;
                pp2_d    = pc_plus2;
                valid_d  = 1'b0;
                ifid_wen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'h0000;
        end else if (stall_inc && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    fetch_ctrl_dff #(.WIDTH(WORD_W), .RESET_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .wen (pc_wen),
        .d   (pc_d),
        .q   (pc_q)
    );

    fetch_ctrl_dff #(.WIDTH(WORD_W), .RESET_VAL(BUBBLE)) u_if_id_instr (
        .clk (clk),
        .rst (rst),
        .wen (ifid_wen),
        .d   (instr_d),
        .q   (if_id_instr)
    );

    fetch_ctrl_dff #(.WIDTH(WORD_W), .RESET_VAL(16'h0000)) u_if_id_pc_plus2 (
        .clk (clk),
        .rst (rst),
        .wen (ifid_wen),
        .d   (pp2_d),
        .q   (if_id_pc_plus2)
    );

    fetch_ctrl_dff #(.WIDTH(1), .RESET_VAL(1'b0)) u_if_id_valid (
        .clk (clk),
        .rst (rst),
        .wen (ifid_wen),
        .d   (valid_d),
        .q   (if_id_valid)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        hlt;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .hlt            (hlt),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .stall_cycles   (stall_cycles)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                              input logic [15:0] pp2, input logic valid, input logic hl,
                              input logic [15:0] sc);
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pp2"},   if_id_pc_plus2, pp2);
        check({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, valid});
        check({tag, ".halt"},  {15'd0, halted}, {15'd0, hl});
        check({tag, ".stc"},   stall_cycles, sc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; hlt = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000; imem_data = 16'h1234;
        step();
        step();
        expect_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            step();
            expect_all($sformatf("seq%0d", k), 16'(2 * k), 16'h1234, 16'(2 * k), 1'b1, 1'b0, 16'h0000);
        end

        do_reset();
        for (int k = 1; k <= 3; k++) step();
        check("pre_stall.addr", imem_addr, 16'h0006);
        stall = 1'b1;
        imem_data = 16'h5555;
        for (int k = 1; k <= 3; k++) begin
            step();
            expect_all($sformatf("stall%0d", k), 16'h0006, 16'h1234, 16'h0006, 1'b1, 1'b0, 16'(k));
        end
        stall = 1'b0;
        step();
        expect_all("release", 16'h0008, 16'h5555, 16'h0008, 1'b1, 1'b0, 16'h0003);

        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
        step();
        expect_all("br_stall", 16'h0040, 16'h0000, 16'h0040, 1'b0, 1'b0, 16'h0003);
        stall = 1'b0; branch_taken = 1'b0;
        imem_data = 16'h1234;
        step();
        expect_all("after_br", 16'h0042, 16'h1234, 16'h0042, 1'b1, 1'b0, 16'h0003);

        branch_taken = 1'b1; branch_target = 16'h000A;
        step();
        branch_taken = 1'b0;
        check("to_0a.addr", imem_addr, 16'h000A);
        imem_data = 16'hF000;
        step();
        expect_all("hlt_fetch", 16'h000A, 16'hF000, 16'h000C, 1'b1, 1'b0, 16'h0003);
        imem_data = 16'h1234;
        step();
        expect_all("pend1", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b0, 16'h0003);
        step();
        expect_all("pend2", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b0, 16'h0003);
        stall = 1'b1;
        step();
        expect_all("pend_stall", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b0, 16'h0004);
        hlt = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
        step();
        expect_all("halt", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1, 16'h0004);
        for (int k = 0; k < 10; k++) begin
            stall = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            branch_target = 16'($urandom);
            imem_data = 16'($urandom);
            step();
            expect_all($sformatf("frozen%0d", k), 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1, 16'h0004);
        end

        rst = 1'b1; stall = 1'b1; branch_taken = 1'b1;
        step();
        expect_all("rst_halted", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0; hlt = 1'b0; stall = 1'b0; branch_taken = 1'b0;

        imem_data = 16'hF123;
        step();
        expect_all("hlt2", 16'h0000, 16'hF123, 16'h0002, 1'b1, 1'b0, 16'h0000);
        imem_data = 16'h1234;
        step();
        expect_all("pend3", 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000);
        branch_taken = 1'b1; branch_target = 16'h0020;
        step();
        expect_all("pend_br", 16'h0020, 16'h0000, 16'h0020, 1'b0, 1'b0, 16'h0000);
        branch_taken = 1'b0;
        step();
        expect_all("resume", 16'h0022, 16'h1234, 16'h0022, 1'b1, 1'b0, 16'h0000);

        branch_taken = 1'b1; branch_target = 16'h1235;
        step();
        check("odd_target", imem_addr, 16'h1235);

        branch_target = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        check("pre_wrap", imem_addr, 16'hFFFE);
        step();
        expect_all("wrap", 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000);

        rst = 1'b1; hlt = 1'b1; imem_data = 16'hF000;
        step();
        expect_all("rst_prio", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter BUBBLE, default 16'h0000, instruction word inserted into IF/ID on flush or halt.
REQ-003 Parameter HLT_OP, default 4'b1111, opcode field [15:12] identifying the HLT instruction.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold request from the hazard detection unit.
REQ-007 hlt  input  1  halt-commit indication from the hazard detection unit; level, sticky at source.
REQ-008 branch_taken  input  1  redirect request resolved downstream.
REQ-009 branch_target  input  16  redirect PC, valid when branch_taken=1.
REQ-010 imem_data  input  16  instruction memory read data for imem_addr; combinational, same cycle.
REQ-011 imem_addr  output  16  current PC, registered.
REQ-012 if_id_instr  output  16  IF/ID instruction register.
REQ-013 if_id_pc_plus2  output  16  IF/ID register holding fetch PC + 2.
REQ-014 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction; 0 = bubble.
REQ-015 halted  output  1  1 while in HALTED state.
REQ-016 stall_cycles  output  16  saturating count of cycles held by stall.

Function
REQ-017 FSM states SHALL be FETCH, HALT_PEND and HALTED.
REQ-018 Event priority per cycle SHALL be rst > hlt > branch_taken > stall > normal operation.
REQ-019 FETCH, no event: PC <= PC+2 (mod 2^16, wraps FFFE->0000); IF/ID <= {imem_data, PC+2, valid=1}.
REQ-020 FETCH, no event, imem_data[15:12]==HLT_OP: IF/ID loads the HLT word as in REQ-019, but PC holds and state -> HALT_PEND.
REQ-021 HALT_PEND, no event: PC holds; IF/ID <= {BUBBLE, PC+2, valid=0}.
REQ-022 stall=1 in FETCH or HALT_PEND: PC, IF/ID and state hold; stall_cycles increments and saturates at 16'hFFFF.
REQ-023 branch_taken=1 in FETCH or HALT_PEND: PC <= branch_target; IF/ID <= {BUBBLE, branch_target, valid=0}; state -> FETCH; stall ignored that cycle and stall_cycles not incremented.
REQ-024 hlt=1 in any state: state -> HALTED; PC and IF/ID hold in that cycle and thereafter.
REQ-025 HALTED: PC, IF/ID and stall_cycles frozen; halted=1; all inputs except rst ignored.
REQ-026 Latency: imem_data sampled in cycle N SHALL appear on if_id_instr in cycle N+1.
REQ-027 Branch target with odd LSB SHALL be loaded unmodified; no alignment check.

Reset
REQ-028 On rst=1 at a clock edge, in any state including mid-stall, HALT_PEND or HALTED: PC=RESET_PC, if_id_instr=BUBBLE, if_id_pc_plus2=16'h0000, if_id_valid=0, stall_cycles=0, state=FETCH, halted=0.
REQ-029 rst SHALL override every other input in the same cycle.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, HLT_OP, BUBBLE, and the 16-bit word-width constant.
REQ-031 PC and IF/ID fields SHALL be built from the codebase's existing dff sub-module (d, q, wen, clk, rst), using wen for hold.
REQ-032 No other sub-modules.

Verification
REQ-033 Reset, then 4 cycles of imem_data=16'h1234, no events -> imem_addr 0002,0004,0006,0008; if_id_pc_plus2 tracks; if_id_valid=1.
REQ-034 PC=0006, stall=1 for 3 cycles -> imem_addr stays 0006, IF/ID unchanged, stall_cycles=3; release -> PC 0008 next cycle.
REQ-035 stall=1 and branch_taken=1 with target 0040 in the same cycle -> PC=0040, if_id_valid=0, if_id_pc_plus2=0040, stall_cycles unchanged.
REQ-036 imem_data=16'hF000 at PC=000A -> if_id_instr=F000 next cycle, PC holds 000A, following cycles bubbles; assert hlt -> halted=1, all outputs frozen for 10 cycles under random stall/branch.
REQ-037 HLT fetched then branch_taken target 0020 before hlt -> state FETCH, PC=0020, fetching resumes; rst in HALTED -> all REQ-028 values next cycle.
REQ-038 PC=FFFE, no events -> PC wraps to 0000, if_id_pc_plus2=0000.
